// File: rtl/base_rr_arb_mux_if.sv
// base_rr_arb_mux_if
//   Bundles the request side and the registered output side of the
//   round-robin arbiter/mux so both ends can be passed as one port.
//
//   Request side (one channel per way, way 0 is the leftmost slice):
//     i_v   [0:ways-1]        per-way request valid
//     i_r   [0:ways-1]        per-way accept, at most one bit set
//     i_d   [0:ways*width-1]  way j data at bits j*width .. j*width+width-1
//   Output side:
//     o_v   1                 output register holds a valid beat
//     o_r   1                 downstream ready
//     o_d   [0:width-1]       registered winning data
//     o_sel [0:ways-1]        one-hot way that produced o_d, zero when idle
//
//   master: the environment (drives requests and downstream ready)
//   slave : the arbiter itself
interface base_rr_arb_mux_if #(
  parameter int width = 1,
  parameter int ways  = 1
);

  logic [0:ways-1]       i_v;
  logic [0:ways-1]       i_r;
  logic [0:ways*width-1] i_d;
  logic                  o_v;
  logic                  o_r;
  logic [0:width-1]      o_d;
  logic [0:ways-1]       o_sel;

  modport master (
    output i_v, i_d, o_r,
    input  i_r, o_v, o_d, o_sel
  );

  modport slave (
    input  i_v, i_d, o_r,
    output i_r, o_v, o_d, o_sel
  );

endinterface

// File: rtl/base_rr_arb_mux.sv
// base_or
//   Multi-way OR reducer: ORs `ways` slices of `width` bits down to one
//   slice. When at most one slice is non-zero it behaves as a mux.
//     d  [0:ways*width-1]  way j occupies bits j*width .. j*width+width-1
//     q  [0:width-1]       bitwise OR of all slices
//
// base_rr_arb_mux
//   Round-robin arbiter plus data gate in front of base_or. Each cycle the
//   output stage can load, one requesting way is granted, every other way's
//   data is forced to zero, and the OR of the gated ways is captured in a
//   one-entry valid/ready output register together with the one-hot
//   identity of the winner.
//     clk    clock, all state on the rising edge
//     reset  asynchronous, active-high reset
//     bus    base_rr_arb_mux_if slave modport (requests and output beat)

module base_or #(
  parameter int width = 1,
  parameter int ways  = 1
) (
  input  logic [0:ways*width-1] d,
  output logic [0:width-1]      q
);

  // Fold every way's slice into the result; the caller guarantees that
  // only the granted slice can be non-zero, so this acts as a selector.
  always_comb begin
    q = '0;
    for (int j = 0; j < ways; j++) begin
      q = q | d[j*width +: width];
    end
  end

endmodule

module base_rr_arb_mux #(
  parameter int width = 1,
  parameter int ways  = 1
) (
  input logic           clk,
  input logic           reset,
  base_rr_arb_mux_if.slave bus
);

  localparam int pw = (ways > 1) ? $clog2(ways) : 1;

  logic [pw-1:0]         ptr;
  logic [pw-1:0]         gnt_idx;
  logic [0:ways-1]       gnt;
  logic                  any_gnt;
  logic                  load;
  logic [0:ways*width-1] masked;
  logic [0:width-1]      or_out;
  logic                  o_v_q;
  logic [0:width-1]      o_d_q;
  logic [0:ways-1]       o_sel_q;
  int                    cand;

  // Round-robin search: start one past the last granted way, walk up to
  // ways-1, wrap to 0 and stop at the first requester. The candidate index
  // is wrapped with a subtraction because ptr+off never reaches 2*ways,
  // which keeps non power-of-two way counts correct without a modulo.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    any_gnt = 1'b0;
    cand    = 0;
    for (int off = 1; off <= ways; off++) begin
      cand = int'(ptr) + off;
      if (cand >= ways) begin
        cand = cand - ways;
      end
      if (!any_gnt && bus.i_v[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = pw'(cand);
        any_gnt   = 1'b1;
      end
    end
  end

  // The output stage can take a new beat when it is empty or being drained
  // this cycle. Accepts are only offered when a load will actually happen,
  // so a stalled output never swallows a request.
  assign load    = !o_v_q || bus.o_r;
  assign bus.i_r = gnt & {ways{load}};

  // Zero every slice except the granted one so the OR reducer sees a
  // one-hot-masked vector and its output equals the winner's data.
  for (genvar j = 0; j < ways; j++) begin : g_mask
    assign masked[j*width +: width] = bus.i_d[j*width +: width] & {width{gnt[j]}};
  end

  base_or #(
    .width (width),
    .ways  (ways)
  ) u_or (
    .d (masked),
    .q (or_out)
  );

  // Output register and round-robin pointer. The pointer only moves on a
  // real grant, so an idle cycle leaves the priority order untouched. Data
  // is held when no way wins, avoiding needless toggling on the data bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_v_q   <= 1'b0;
      o_d_q   <= '0;
      o_sel_q <= '0;
      ptr     <= pw'(ways - 1);
    end else if (load) begin
      o_v_q   <= any_gnt;
      o_sel_q <= gnt;
      if (any_gnt) begin
        o_d_q <= or_out;
        ptr   <= gnt_idx;
      end
    end
  end

  assign bus.o_v   = o_v_q;
  assign bus.o_d   = o_d_q;
  assign bus.o_sel = o_sel_q;

endmodule

// File: tb/tb_base_rr_arb_mux.sv
// tb_base_rr_arb_mux
//   Self-checking bench for base_rr_arb_mux with width=8, ways=4.
//   A behavioural model predicts every grant from the round-robin rule
//   (start after the last winner, wrap, take the first requester) and
//   pushes the expected beat into a scoreboard queue; a monitor running on
//   the falling edge pops and compares whenever the output is handed off.
module tb_base_rr_arb_mux;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] data;
    logic [0:N-1] sel;
  } beat_t;

  logic clk;
  logic reset;

  base_rr_arb_mux_if #(.width(W), .ways(N)) bus ();

  base_rr_arb_mux #(
    .width (W),
    .ways  (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  beat_t        sb_q[$];
  int           m_last;
  logic         m_ov;
  logic [W-1:0] m_od;
  logic [0:N-1] m_osel;
  logic [0:N-1] m_acc;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected it to end");
    $fatal(1, "[TB] watchdog expired");
  end

  // First requesting way after `last` in wrap-around order, or -1.
  function automatic int pick_way(input logic [0:N-1] v, input int last);
    for (int off = 1; off <= N; off++) begin
      int w;
      w = (last + off) % N;
      if (v[w]) return w;
    end
    return -1;
  endfunction

  function automatic logic [0:N-1] one_hot(input int w);
    logic [0:N-1] s;
    s = '0;
    if (w >= 0) s[w] = 1'b1;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [0:N-1] v, input logic [0:N*W-1] d, input logic r);
    bus.i_v = v;
    bus.i_d = d;
    bus.o_r = r;
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks what the output register should hold. On each
  // rising edge where the output can load, the round-robin winner (if any)
  // becomes the new expected beat and is queued for the monitor.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_last <= N - 1;
      m_ov   <= 1'b0;
      m_od   <= '0;
      m_osel <= '0;
      m_acc  <= '0;
      sb_q.delete();
    end else begin
      int    w;
      beat_t b;
      w = pick_way(bus.i_v, m_last);
      if (!m_ov || bus.o_r) begin
        if (w >= 0) begin
          b.data = bus.i_d[w*W +: W];
          b.sel  = one_hot(w);
          sb_q.push_back(b);
          m_ov   <= 1'b1;
          m_od   <= b.data;
          m_osel <= b.sel;
          m_last <= w;
          m_acc  <= b.sel;
        end else begin
          m_ov   <= 1'b0;
          m_osel <= '0;
          m_acc  <= '0;
        end
      end else begin
        m_acc <= '0;
      end
    end
  end

  // Monitor: away from the active edge, compare the accept vector and the
  // output register against the model, and pop the scoreboard whenever the
  // downstream side takes the current beat.
  always @(negedge clk) begin
    if (!reset) begin
      logic [0:N-1] exp_ir;
      int           w;
      beat_t        b;
      w      = pick_way(bus.i_v, m_last);
      exp_ir = (!m_ov || bus.o_r) ? one_hot(w) : '0;
      checkOutput("i_r", 32'(bus.i_r), 32'(exp_ir));
      checkOutput("i_r_onehot0", 32'($onehot0(bus.i_r)), 32'd1);
      checkOutput("o_sel_onehot0", 32'($onehot0(bus.o_sel)), 32'd1);
      checkOutput("o_v", 32'(bus.o_v), 32'(m_ov));
      checkOutput("o_d_state", 32'(bus.o_d), 32'(m_od));
      checkOutput("o_sel_state", 32'(bus.o_sel), 32'(m_osel));
      if (bus.o_v && bus.o_r) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL sb_empty: got beat %0h, expected no beat at %0t", bus.o_d, $time);
        end else begin
          b = sb_q.pop_front();
          checkOutput("sb_o_d", 32'(bus.o_d), 32'(b.data));
          checkOutput("sb_o_sel", 32'(bus.o_sel), 32'(b.sel));
        end
      end
    end
  end

  logic [7:0] seq_d[5]   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [0:3] seq_s[5]   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic [7:0] pair_d[3]  = '{8'h33, 8'h44, 8'h33};

  // Directed scenarios first, then a randomized stretch that respects the
  // rule that an unaccepted request keeps its valid and data stable.
  initial begin
    logic [0:N-1]   cur_v;
    logic [0:N*W-1] cur_d;

    reset   = 1'b1;
    bus.i_v = '0;
    bus.i_d = '0;
    bus.o_r = 1'b0;
    #1;
    checkOutput("rst_o_v", 32'(bus.o_v), 32'd0);
    checkOutput("rst_o_sel", 32'(bus.o_sel), 32'd0);
    checkOutput("rst_o_d", 32'(bus.o_d), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] round-robin sequence over all four ways");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 32'h11223344, 1'b1);
      checkOutput("seq_o_d", 32'(bus.o_d), 32'(seq_d[i]));
      checkOutput("seq_o_sel", 32'(bus.o_sel), 32'(seq_s[i]));
    end
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 32'h11223344, 1'b1);

    $display("[TB] two requesters after way 3 won");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0011, 32'h11223344, 1'b1);
      checkOutput("pair_o_d", 32'(bus.o_d), 32'(pair_d[i]));
    end

    $display("[TB] backpressure");
    applyStimulus(4'b0100, 32'h11223344, 1'b1);
    checkOutput("bp_first_o_d", 32'(bus.o_d), 32'h22);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0010, 32'h11223344, 1'b0);
      checkOutput("bp_i_r", 32'(bus.i_r), 32'd0);
      checkOutput("bp_o_d", 32'(bus.o_d), 32'h22);
      checkOutput("bp_o_sel", 32'(bus.o_sel), 32'(4'b0100));
    end
    applyStimulus(4'b0010, 32'h11223344, 1'b1);
    checkOutput("bp_release_o_v", 32'(bus.o_v), 32'd1);
    checkOutput("bp_release_o_d", 32'(bus.o_d), 32'h33);

    $display("[TB] idle");
    applyStimulus(4'b0000, 32'h11223344, 1'b1);
    checkOutput("idle_o_v", 32'(bus.o_v), 32'd0);
    checkOutput("idle_o_sel", 32'(bus.o_sel), 32'd0);
    checkOutput("idle_o_d", 32'(bus.o_d), 32'h33);
    applyStimulus(4'b0100, 32'h11223344, 1'b1);
    checkOutput("idle_next_o_sel", 32'(bus.o_sel), 32'(4'b0100));

    $display("[TB] masking");
    applyStimulus(4'b0010, 32'hFFFF5AFF, 1'b1);
    checkOutput("mask_o_d", 32'(bus.o_d), 32'h5A);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(4'b1111, 32'h11223344, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_o_v", 32'(bus.o_v), 32'd0);
    checkOutput("async_o_sel", 32'(bus.o_sel), 32'd0);
    checkOutput("async_o_d", 32'(bus.o_d), 32'd0);
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_o_d", 32'(bus.o_d), 32'h11);
    checkOutput("post_rst_o_sel", 32'(bus.o_sel), 32'(4'b1000));

    $display("[TB] randomized traffic");
    cur_v = bus.i_v;
    cur_d = bus.i_d;
    for (int c = 0; c < 400; c++) begin
      for (int w = 0; w < N; w++) begin
        if (!(cur_v[w] && !m_acc[w])) begin
          cur_v[w]         = ($urandom_range(0, 99) < 55);
          cur_d[w*W +: W]  = W'($urandom);
        end
      end
      applyStimulus(cur_v, cur_d, ($urandom_range(0, 99) < 70));
    end
    applyStimulus('0, cur_d, 1'b1);
    applyStimulus('0, cur_d, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
